// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the WM8731-style I2C write responder.
package i2c_resp_pkg;

  localparam int ADDR_BITS = 7;
  localparam int DATA_BITS = 9;
  localparam logic [ADDR_BITS-1:0] CODEC_RESET_REG = 7'h0F;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_A,
    HI,
    ACK_H,
    LO,
    ACK_L,
    DONE,
    IGNORE
  } state_t;

  // Byte phase that follows each ACK slot.
  function automatic state_t next_after_ack(input state_t s);
    case (s)
      ACK_A:   return HI;
      ACK_H:   return LO;
      default: return DONE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the system clock and flags SCL edges plus START/STOP.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_prev_reg;
  logic                   sda_prev_reg;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_stable_high;

  // Reset to 1 so a released bus does not look like a START after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], i_scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], i_sda};
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
    end
  end

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  // An SCL edge in the same cycle as an SDA edge counts as SCL low.
  assign scl_stable_high = scl_s & scl_prev_reg;

  assign o_sda      = sda_s;
  assign o_scl_rise = scl_s & ~scl_prev_reg;
  assign o_scl_fall = ~scl_s & scl_prev_reg;
  assign o_start    = ~sda_s & sda_prev_reg & scl_stable_high;
  assign o_stop     = sda_s & ~sda_prev_reg & scl_stable_high;

endmodule

// File: rtl/i2c_codec_responder.sv
// WM8731 control-port responder: ACKs 3-byte write frames and emits register writes.
// Optional shadow register file enabled by defining I2C_RESP_SHADOW_EN.
module i2c_codec_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scl,
  input  logic                 i_sda,
  output logic                 o_sda_oe,
  output logic                 o_wr_valid,
  output logic [ADDR_BITS-1:0] o_wr_addr,
  output logic [DATA_BITS-1:0] o_wr_data,
  output logic                 o_nack,
  output logic                 o_busy,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data
);

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (sda_s),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (bus_start),
    .o_stop     (bus_stop)
  );

  state_t                 state_reg, state_next;
  logic [2:0]             bit_cnt_reg, bit_cnt_next;
  logic [7:0]             shift_reg, shift_next;
  logic [7:0]             hi_reg, hi_next;
  logic                   sda_oe_reg, sda_oe_next;
  logic                   wr_valid_reg, wr_valid_next;
  logic                   nack_reg, nack_next;
  logic                   busy_reg, busy_next;
  logic [ADDR_BITS-1:0]   wr_addr_reg, wr_addr_next;
  logic [DATA_BITS-1:0]   wr_data_reg, wr_data_next;
  logic [7:0]             byte_in;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      hi_reg       <= '0;
      sda_oe_reg   <= 1'b0;
      wr_valid_reg <= 1'b0;
      nack_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      hi_reg       <= hi_next;
      sda_oe_reg   <= sda_oe_next;
      wr_valid_reg <= wr_valid_next;
      nack_reg     <= nack_next;
      busy_reg     <= busy_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    hi_next       = hi_reg;
    sda_oe_next   = sda_oe_reg;
    wr_valid_next = 1'b0;
    nack_next     = 1'b0;
    busy_next     = busy_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    byte_in       = {shift_reg[6:0], sda_s};

    if (bus_start) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      shift_next   = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b1;
    end else if (bus_stop) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else begin
      case (state_reg)
        ADDR, HI, LO: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              case (state_reg)
                ADDR: begin
                  if (byte_in == {DEV_ADDR, 1'b0}) begin
                    state_next = ACK_A;
                  end else begin
                    nack_next  = 1'b1;
                    state_next = IGNORE;
                  end
                end
                HI: begin
                  hi_next    = byte_in;
                  state_next = ACK_H;
                end
                default: state_next = ACK_L;
              endcase
            end
          end
        end
        // First fall pulls SDA low for the ACK slot, the second releases it.
        ACK_A, ACK_H, ACK_L: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              state_next   = next_after_ack(state_reg);
              if (state_reg == ACK_L) begin
                wr_addr_next  = hi_reg[7:1];
                wr_data_next  = {hi_reg[0], shift_reg};
                wr_valid_next = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_RESP_SHADOW_EN
  logic [DATA_BITS-1:0] shadow_q [16];
  logic                 codec_reset;

  assign codec_reset = wr_valid_reg && (wr_addr_reg == CODEC_RESET_REG);

  for (genvar gi = 0; gi < 16; gi++) begin : g_shadow
    logic [DATA_BITS-1:0] entry_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        entry_reg <= '0;
      end else if (codec_reset) begin
        entry_reg <= '0;
      end else if (wr_valid_reg && (wr_addr_reg[3:0] == 4'(gi))) begin
        entry_reg <= wr_data_reg;
      end
    end

    assign shadow_q[gi] = entry_reg;
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^i_rd_addr;
`endif

  always_comb begin
    o_sda_oe   = sda_oe_reg;
    o_wr_valid = wr_valid_reg;
    o_wr_addr  = wr_addr_reg;
    o_wr_data  = wr_data_reg;
    o_nack     = nack_reg;
    o_busy     = busy_reg;
`ifdef I2C_RESP_SHADOW_EN
    o_rd_data  = (i_rd_addr[6:4] == 3'd0) ? shadow_q[i_rd_addr[3:0]] : '0;
`else
    o_rd_data  = '0;
`endif
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: bit-banged I2C master with open-drain SDA.
module tb_i2c_codec_responder;

  localparam int Q = 30;  // quarter SCL period in system clocks (~100 kHz)

`ifdef I2C_RESP_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       scl    = 1'b1;
  logic       sda_m  = 1'b1;
  logic [6:0] rd_addr = 7'h00;

  logic       sda_oe, wr_valid, nack, busy;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  int   errors  = 0;
  int   checks  = 0;
  int   wr_cnt  = 0;
  int   nack_cnt = 0;
  int   ack_cnt = 0;
  logic oe_prev = 1'b0;

  always #42 clk = ~clk;

  i2c_codec_responder #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (scl),
    .i_sda      (sda_line),
    .o_sda_oe   (sda_oe),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_nack     (nack),
    .o_busy     (busy),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data)
  );

  always @(negedge clk) begin
    if (wr_valid) wr_cnt++;
    if (nack) nack_cnt++;
    if (sda_oe && !oe_prev) ack_cnt++;
    oe_prev = sda_oe;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic do_start;
    sda_m = 1'b1; wait_q(1);
    scl   = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl   = 1'b0; wait_q(1);
  endtask

  task automatic do_stop;
    sda_m = 1'b0; wait_q(1);
    scl   = 1'b1; wait_q(1);
    sda_m = 1'b1; wait_q(2);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q(1);
      scl   = 1'b1; wait_q(2);
      scl   = 1'b0; wait_q(1);
    end
  endtask

  task automatic ack_phase(output logic ack);
    sda_m = 1'b1; wait_q(1);
    scl   = 1'b1; wait_q(1);
    ack   = ~sda_line; wait_q(1);
    scl   = 1'b0; wait_q(1);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    ack_phase(ack);
  endtask

  task automatic run_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [2:0] exp_ack, input int exp_wr,
                           input int exp_nack, input logic [6:0] exp_addr, input logic [8:0] exp_data);
    int wr0, ack0, nack0;
    logic [2:0] acks;
    wr0 = wr_cnt; ack0 = ack_cnt; nack0 = nack_cnt;
    do_start;
    check_eq({name, "_busy_hi"}, busy, 1);
    send_byte(b0, acks[2]);
    send_byte(b1, acks[1]);
    send_byte(b2, acks[0]);
    do_stop;
    check_eq({name, "_acks"}, acks, exp_ack);
    check_eq({name, "_ack_pulses"}, ack_cnt - ack0, $countones(exp_ack));
    check_eq({name, "_wr_cnt"}, wr_cnt - wr0, exp_wr);
    check_eq({name, "_nack_cnt"}, nack_cnt - nack0, exp_nack);
    check_eq({name, "_addr"}, wr_addr, exp_addr);
    check_eq({name, "_data"}, wr_data, exp_data);
    check_eq({name, "_busy_lo"}, busy, 0);
  endtask

  initial begin
    int   wr0, ack0;
    logic a0, a1, a2, a3;

    repeat (5) @(negedge clk);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_wr_valid", wr_valid, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_nack", nack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    run_frame("f_1e00", 8'h34, 8'h1E, 8'h00, 3'b111, 1, 0, 7'h0F, 9'h000);
    run_frame("f_0815", 8'h34, 8'h08, 8'h15, 3'b111, 1, 0, 7'h04, 9'h015);
    rd_addr = 7'h04; @(negedge clk);
    check_eq("shadow_rd4", rd_data, SHADOW ? 9'h015 : 9'h000);
    rd_addr = 7'h14; @(negedge clk);
    check_eq("shadow_rd14_oob", rd_data, 0);

    // Data bit 8 from HI byte, plus an extra byte after DONE that must not be ACKed.
    wr0 = wr_cnt; ack0 = ack_cnt;
    do_start;
    send_byte(8'h34, a0);
    send_byte(8'h0D, a1);
    send_byte(8'hFF, a2);
    send_byte(8'h55, a3);
    do_stop;
    check_eq("f_0dff_acks", {a0, a1, a2, a3}, 4'b1110);
    check_eq("f_0dff_ack_pulses", ack_cnt - ack0, 3);
    check_eq("f_0dff_wr_cnt", wr_cnt - wr0, 1);
    check_eq("f_0dff_addr", wr_addr, 7'h06);
    check_eq("f_0dff_data", wr_data, 9'h1FF);

    run_frame("f_nack36", 8'h36, 8'h08, 8'h15, 3'b000, 0, 1, 7'h06, 9'h1FF);
    run_frame("f_1201", 8'h34, 8'h12, 8'h01, 3'b111, 1, 0, 7'h09, 9'h001);

    // Repeated START after the HI byte aborts the partial frame.
    wr0 = wr_cnt;
    do_start;
    send_byte(8'h34, a0);
    send_byte(8'h08, a1);
    do_start;
    send_byte(8'h34, a0);
    send_byte(8'h0C, a1);
    send_byte(8'h00, a2);
    do_stop;
    check_eq("rstart_wr_cnt", wr_cnt - wr0, 1);
    check_eq("rstart_addr", wr_addr, 7'h06);
    check_eq("rstart_data", wr_data, 9'h000);

    // Reset pulse while the responder holds the ACK for the HI byte.
    wr0 = wr_cnt;
    do_start;
    send_byte(8'h34, a0);
    send_bits(8'h08);
    check_eq("ackh_oe_before_rst", sda_oe, 1);
    #10 rst_n = 1'b0;
    #1;
    check_eq("ackh_oe_async_clr", sda_oe, 0);
    check_eq("ackh_busy_clr", busy, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    sda_m = 1'b1; wait_q(1);
    scl   = 1'b1; wait_q(2);
    scl   = 1'b0; wait_q(1);
    do_stop;
    check_eq("ackh_rst_wr_cnt", wr_cnt - wr0, 0);
    check_eq("ackh_rst_addr", wr_addr, 0);
    check_eq("ackh_rst_data", wr_data, 0);

    run_frame("f_0e4a", 8'h34, 8'h0E, 8'h4A, 3'b111, 1, 0, 7'h07, 9'h04A);
    run_frame("f_0815b", 8'h34, 8'h08, 8'h15, 3'b111, 1, 0, 7'h04, 9'h015);
    rd_addr = 7'h04; @(negedge clk);
    check_eq("shadow_rd4_b", rd_data, SHADOW ? 9'h015 : 9'h000);
    rd_addr = 7'h07; @(negedge clk);
    check_eq("shadow_rd7", rd_data, SHADOW ? 9'h04A : 9'h000);

    run_frame("f_1e00b", 8'h34, 8'h1E, 8'h00, 3'b111, 1, 0, 7'h0F, 9'h000);
    rd_addr = 7'h04; @(negedge clk);
    check_eq("shadow_rd4_cleared", rd_data, 0);
    rd_addr = 7'h07; @(negedge clk);
    check_eq("shadow_rd7_cleared", rd_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
